// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default
// parameter values and a width helper for channel indices.
package fetch_sequencer_pkg;

  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_SDRAM_AW = 19;
  localparam int DEF_RAM_AW   = 12;
  localparam int DEF_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Channel index width; a single channel still needs one bit of storage.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_ch_select.sv
// Channel selector for the fetch sequencer.
// Returns the lowest enabled channel (from_start=1) or the lowest enabled
// channel strictly above 'cur' (from_start=0). 'none' flags that no such
// channel exists.
// Ports:
//   mask        in   NUM_CH   channel enable mask
//   from_start  in   1        search from channel 0 instead of above cur
//   cur         in   CW       current channel
//   next_ch     out  CW       selected channel (0 when none)
//   none        out  1        no qualifying channel
module fetch_ch_select
  import fetch_sequencer_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CW     = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic              from_start,
  input  logic [CW-1:0]     cur,
  output logic [CW-1:0]     next_ch,
  output logic              none
);

  // Scanning downward lets the lowest qualifying channel overwrite any
  // higher one, giving lowest-index priority.
  always_comb begin
    next_ch = '0;
    none    = 1'b1;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (from_start || (k > int'(cur)))) begin
        next_ch = CW'(k);
        none    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-channel SDRAM-to-BRAM fetch sequencer.
// For each word index, reads one word per enabled channel from SDRAM at
// base[ch]+index and then strobes that channel's RAM write.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_start             job start pulse (IDLE only)
//   i_abort             abandon current job
//   i_length            words per channel, latched at start
//   i_chEnable          channel mask, latched at start
//   i_baseAddr          flattened per-channel SDRAM bases, latched at start
//   i_sdramReady        read data valid (WAIT only)
//   o_rdSdram           one-cycle read request
//   o_addrToSdram       read address
//   o_wrRam             one-hot RAM write strobe
//   o_addrToRam         current word index
//   o_busy              job in progress
//   o_finish            normal completion pulse
//   o_error             SDRAM wait timeout pulse
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SDRAM_AW = DEF_SDRAM_AW,
  parameter int RAM_AW   = DEF_RAM_AW,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [RAM_AW:0]            i_length,
  input  logic [NUM_CH-1:0]          i_chEnable,
  input  logic [NUM_CH*SDRAM_AW-1:0] i_baseAddr,
  input  logic                       i_sdramReady,
  output logic                       o_rdSdram,
  output logic [SDRAM_AW-1:0]        o_addrToSdram,
  output logic [NUM_CH-1:0]          o_wrRam,
  output logic [RAM_AW-1:0]          o_addrToRam,
  output logic                       o_busy,
  output logic                       o_finish,
  output logic                       o_error
);

  localparam int CW = ch_width(NUM_CH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                           state, state_d;
  logic [RAM_AW:0]                  index;
  logic [RAM_AW:0]                  len_q;
  logic [CW-1:0]                    ch;
  logic [NUM_CH-1:0]                mask_q;
  logic [NUM_CH-1:0][SDRAM_AW-1:0]  base_q;
  logic [TW-1:0]                    wait_cnt;
  logic                             error_q, error_d;

  logic [NUM_CH-1:0]                sel_mask;
  logic                             sel_from_start;
  logic [CW-1:0]                    sel_ch;
  logic                             sel_none;
  logic                             timeout_hit;
  logic                             last_index;

  // One selector serves all three lookups: lowest enabled channel of the
  // incoming mask at start, next channel above the current one after a
  // write, and lowest latched channel when moving to the next index.
  assign sel_mask       = (state == S_IDLE) ? i_chEnable : mask_q;
  assign sel_from_start = (state != S_WRITE);

  fetch_ch_select #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_ch_select (
    .mask       (sel_mask),
    .from_start (sel_from_start),
    .cur        (ch),
    .next_ch    (sel_ch),
    .none       (sel_none)
  );

  // The counter holds completed WAIT cycles, so matching TIMEOUT-1 during a
  // WAIT cycle means this is the TIMEOUT-th cycle spent waiting.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));
  assign last_index  = (index == (len_q - 1'b1));

  // Next-state decode. Abort overrides everything outside IDLE; in WAIT a
  // ready beats a coincident timeout.
  always_comb begin
    state_d = state;
    error_d = 1'b0;
    if ((state != S_IDLE) && i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state_d = ((i_length != '0) && (i_chEnable != '0)) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (i_sdramReady) begin
            state_d = S_WRITE;
          end else if (timeout_hit) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end
        S_WRITE: state_d = sel_none ? S_NEXT : S_ISSUE;
        S_NEXT:  state_d = last_index ? S_DONE : S_ISSUE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register plus the job datapath. Job parameters are captured only
  // on an accepted start so later input changes cannot disturb a job.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      error_q  <= 1'b0;
      index    <= '0;
      len_q    <= '0;
      ch       <= '0;
      mask_q   <= '0;
      base_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state   <= state_d;
      error_q <= error_d;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            len_q  <= i_length;
            mask_q <= i_chEnable;
            base_q <= i_baseAddr;
            index  <= '0;
            ch     <= sel_ch;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (!sel_none) begin
            ch <= sel_ch;
          end
        end
        S_NEXT: begin
          index <= index + 1'b1;
          ch    <= sel_ch;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded purely from registered state.
  assign o_rdSdram     = (state == S_ISSUE);
  assign o_addrToSdram = base_q[ch] + SDRAM_AW'(index);
  assign o_wrRam       = (state == S_WRITE) ? (NUM_CH'(1) << ch) : '0;
  assign o_addrToRam   = index[RAM_AW-1:0];
  assign o_busy        = (state != S_IDLE);
  assign o_finish      = (state == S_DONE);
  assign o_error       = error_q;

endmodule
